// File: rtl/bp_pkg.sv
// Shared definitions for the bimodal branch predictor.
//   DEF_IDX_W  : default table index width (64 counters)
//   CTR_W      : saturating counter width; MSB is the taken prediction
//   CTR_INIT   : reset value of every counter (weakly not-taken)
//   ctr_t      : one table entry
//   sat_update : next value of a counter after a resolved branch
package bp_pkg;

    localparam int DEF_IDX_W = 6;
    localparam int CTR_W     = 2;

    typedef logic [CTR_W-1:0] ctr_t;

    localparam ctr_t CTR_INIT = 2'b01;

    // Step toward the actual outcome, clamping at both ends so a long run
    // of one direction never wraps into the opposite prediction.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t next_ctr;
        next_ctr = ctr;
        if (taken) begin
            if (ctr != {CTR_W{1'b1}}) next_ctr = ctr + 1'b1;
        end else begin
            if (ctr != '0) next_ctr = ctr - 1'b1;
        end
        return next_ctr;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating direction counter of the predictor table.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset, loads INIT
//   en     : train this counter on the current edge
//   taken  : actual branch outcome (1 = count up, 0 = count down)
//   value  : current counter value
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter ctr_t INIT = CTR_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             taken,
    output logic [CTR_W-1:0] value
);

    // NOTE: the table is built from flops rather than a RAM so the async
    // reset reaches every entry; a RAM macro could not be cleared this way.
    // NOTE: state is updated with <= so every counter samples the old values
    // of its inputs on the same edge, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= INIT;
        end else if (en) begin
            value <= sat_update(value, taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch-direction predictor for the fetch stage.
//   clk, reset        : clock and asynchronous active-high reset
//   f_pc              : PC being fetched
//   f_pred_taken      : predicted direction for f_pc (combinational)
//   f_pred_idx        : table index used, carried down the pipe
//   d_valid           : decode instruction valid and not stalled
//   d_is_branch       : decode instruction is a conditional branch
//   d_idx             : f_pred_idx carried with the decode instruction
//   d_pred_taken      : f_pred_taken carried with the decode instruction
//   d_bcres           : actual branch outcome
//   d_mispredict      : resolved branch disagrees with its prediction
//   stat_branches     : resolved branch count (wraps)
//   stat_mispredicts  : mispredicted branch count (wraps)
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      f_pc,
    output logic             f_pred_taken,
    output logic [IDX_W-1:0] f_pred_idx,
    input  logic             d_valid,
    input  logic             d_is_branch,
    input  logic [IDX_W-1:0] d_idx,
    input  logic             d_pred_taken,
    input  logic             d_bcres,
    output logic             d_mispredict,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;

    ctr_t table_q [ENTRIES];
    logic res;

    assign res = d_valid & d_is_branch;

    // PC[1:0] is ignored; upper PC bits alias onto the same entry by design.
    assign f_pred_idx   = f_pc[IDX_W+1:2];
    // Reads the registered table directly: a same-cycle update to this
    // entry becomes visible only from the next cycle.
    assign f_pred_taken = table_q[f_pred_idx][CTR_W-1];
    assign d_mispredict = res & (d_pred_taken ^ d_bcres);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        bp_sat_counter #(
            .INIT (CTR_INIT)
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .en    (res && (d_idx == IDX_W'(g))),
            .taken (d_bcres),
            .value (table_q[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (res) begin
            stat_branches <= stat_branches + 32'd1;
            if (d_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      f_pc;
    logic             f_pred_taken;
    logic [IDX_W-1:0] f_pred_idx;
    logic             d_valid;
    logic             d_is_branch;
    logic [IDX_W-1:0] d_idx;
    logic             d_pred_taken;
    logic             d_bcres;
    logic             d_mispredict;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispredicts;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .f_pred_idx       (f_pred_idx),
        .d_valid          (d_valid),
        .d_is_branch      (d_is_branch),
        .d_idx            (d_idx),
        .d_pred_taken     (d_pred_taken),
        .d_bcres          (d_bcres),
        .d_mispredict     (d_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      pc;
        logic             v;
        logic             br;
        logic [IDX_W-1:0] idx;
        logic             pt;
        logic             bc;
        logic             e_pred;
        logic             e_misp;
        logic [IDX_W-1:0] e_idx;
    } vec_t;

    typedef struct {
        logic             pred;
        logic             misp;
        logic [IDX_W-1:0] idx;
    } exp_t;

    localparam int N_VEC = 23;
    vec_t vecs [N_VEC];
    exp_t sb_q [$];

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_mp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic v, input logic br,
                                input logic [IDX_W-1:0] idx, input logic pt, input logic bc,
                                input logic e_pred, input logic e_misp, input logic [IDX_W-1:0] e_idx);
        vec_t r;
        r.pc = pc; r.v = v; r.br = br; r.idx = idx; r.pt = pt; r.bc = bc;
        r.e_pred = e_pred; r.e_misp = e_misp; r.e_idx = e_idx;
        return r;
    endfunction

    // Drive one vector for one cycle; expected outputs go to the scoreboard
    // at drive time and are popped when the outputs settle. Statistics are
    // checked after the edge against counts kept by the bench.
    task automatic apply(input vec_t vv, input string tag);
        exp_t e;
        @(negedge clk);
        f_pc = vv.pc; d_valid = vv.v; d_is_branch = vv.br; d_idx = vv.idx;
        d_pred_taken = vv.pt; d_bcres = vv.bc;
        sb_q.push_back('{pred: vv.e_pred, misp: vv.e_misp, idx: vv.e_idx});
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " f_pred_taken"}, {31'd0, f_pred_taken}, {31'd0, e.pred});
            check({tag, " d_mispredict"}, {31'd0, d_mispredict}, {31'd0, e.misp});
            check({tag, " f_pred_idx"}, {26'd0, f_pred_idx}, {26'd0, e.idx});
        end
        if (vv.v && vv.br) begin
            exp_br = exp_br + 32'd1;
            if (vv.pt ^ vv.bc) exp_mp = exp_mp + 32'd1;
        end
        @(posedge clk);
        #1;
        check({tag, " stat_branches"}, stat_branches, exp_br);
        check({tag, " stat_mispredicts"}, stat_mispredicts, exp_mp);
    endtask

    task automatic idle();
        @(negedge clk);
        d_valid = 1'b0; d_is_branch = 1'b0; d_bcres = 1'b0; d_pred_taken = 1'b0;
    endtask

    initial begin
        //            pc       v  br idx pt bc  pred misp e_idx
        // Saturation up on entry 16 (01 -> 10 -> 11 -> 11)
        vecs[0]  = mk(32'h40,  1, 1, 16, 0, 1,  0, 1, 16);
        vecs[1]  = mk(32'h40,  1, 1, 16, 1, 1,  1, 0, 16);
        vecs[2]  = mk(32'h40,  1, 1, 16, 1, 1,  1, 0, 16);
        vecs[3]  = mk(32'h40,  0, 0, 16, 0, 0,  1, 0, 16);
        // Down with hysteresis: 11 -> 10 (still taken) -> 01 -> 00 -> 00
        vecs[4]  = mk(32'h40,  1, 1, 16, 1, 0,  1, 1, 16);
        vecs[5]  = mk(32'h40,  0, 0, 16, 0, 0,  1, 0, 16);
        vecs[6]  = mk(32'h40,  1, 1, 16, 1, 0,  1, 1, 16);
        vecs[7]  = mk(32'h40,  0, 0, 16, 0, 0,  0, 0, 16);
        vecs[8]  = mk(32'h40,  1, 1, 16, 0, 0,  0, 0, 16);
        vecs[9]  = mk(32'h40,  1, 1, 16, 0, 0,  0, 0, 16);
        // Two taken steps from 00 reach 10: proves the floor held at 00
        vecs[10] = mk(32'h40,  1, 1, 16, 0, 1,  0, 1, 16);
        vecs[11] = mk(32'h40,  1, 1, 16, 0, 1,  0, 1, 16);
        vecs[12] = mk(32'h40,  0, 0, 16, 0, 0,  1, 0, 16);
        // Collision on entry 32: old value this cycle, new value next
        vecs[13] = mk(32'h80,  1, 1, 32, 0, 1,  0, 1, 32);
        vecs[14] = mk(32'h80,  0, 0, 32, 0, 0,  1, 0, 32);
        // Non-branch / invalid never train or count
        vecs[15] = mk(32'h18,  1, 0, 6,  0, 1,  0, 0, 6);
        vecs[16] = mk(32'h18,  1, 0, 6,  0, 1,  0, 0, 6);
        vecs[17] = mk(32'h18,  0, 1, 6,  0, 1,  0, 0, 6);
        vecs[18] = mk(32'h18,  0, 0, 6,  0, 0,  0, 0, 6);
        // Aliasing: train idx 5, then 0x114 and 0x17 read the same entry
        vecs[19] = mk(32'h14,  1, 1, 5,  0, 1,  0, 1, 5);
        vecs[20] = mk(32'h114, 0, 0, 5,  0, 0,  1, 0, 5);
        vecs[21] = mk(32'h14,  0, 0, 5,  0, 0,  1, 0, 5);
        vecs[22] = mk(32'h17,  0, 0, 5,  0, 0,  1, 0, 5);

        reset = 1'b1;
        f_pc = 32'h0; d_valid = 1'b0; d_is_branch = 1'b0; d_idx = '0;
        d_pred_taken = 1'b0; d_bcres = 1'b0;
        #12;
        check("reset f_pred_taken", {31'd0, f_pred_taken}, 32'd0);
        check("reset f_pred_idx", {26'd0, f_pred_idx}, 32'd0);
        check("reset stat_branches", stat_branches, 32'd0);
        check("reset stat_mispredicts", stat_mispredicts, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
        idle();

        // Asynchronous reset in the middle of a cycle discards all training.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        exp_br = 0;
        exp_mp = 0;
        check("midreset stat_branches", stat_branches, 32'd0);
        check("midreset stat_mispredicts", stat_mispredicts, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            f_pc = 32'(i * 4);
            #1;
            check($sformatf("sweep pc=0x%02h f_pred_taken", i * 4), {31'd0, f_pred_taken}, 32'd0);
        end

        // Statistics wrap: preload the branch counter with all-ones.
        @(negedge clk);
        force dut.stat_branches = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branches;
        #1;
        check("preload stat_branches", stat_branches, 32'hFFFF_FFFF);
        exp_br = 32'hFFFF_FFFF;
        apply(mk(32'h0, 1, 1, 0, 0, 0, 0, 0, 0), "wrap");
        check("wrap stat_branches zero", stat_branches, 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
